// File: rtl/vscale_mem_arbiter_pkg.sv
// Shared constants for the vscale memory arbiter: datapath widths, memory access
// types and the data-phase owner encoding.
package vscale_mem_arbiter_pkg;

  localparam int XPR_LEN         = 32;
  localparam int MEM_TYPE_WIDTH  = 3;
  localparam int ARB_OWNER_WIDTH = 2;

  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LB = 3'd0;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LH = 3'd1;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LW = 3'd2;

  typedef enum logic [ARB_OWNER_WIDTH-1:0] {
    ARB_OWNER_NONE = 2'd0,
    ARB_OWNER_IMEM = 2'd1,
    ARB_OWNER_DMEM = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/vscale_arb_starve_ctr.sv
// Fairness counter: counts accepted dmem grants that denied the fetch and
// forces one imem grant once MAX_GRANTS is reached.
module vscale_arb_starve_ctr #(
  parameter int MAX_GRANTS = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic adv_i,
  input  logic dmem_grant_i,
  output logic force_imem_o
);

  localparam int CW = $clog2(MAX_GRANTS + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign force_imem_o = (cnt_q == CW'(MAX_GRANTS));

  // The fetch is requested every cycle, so every accepted dmem grant starves it
  always_comb begin
    cnt_d = cnt_q;
    if (adv_i) begin
      if (dmem_grant_i) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vscale_mem_arbiter.sv
// Shares one pipelined (address/data phase) memory bus between the vscale fetch
// and data ports; dmem has priority. Optional fairness: VSCALE_ARB_FAIR_EN.
module vscale_mem_arbiter
  import vscale_mem_arbiter_pkg::*;
#(
  parameter int MAX_DMEM_GRANTS = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [XPR_LEN-1:0]        imem_addr_i,
  output logic                      imem_wait_o,
  output logic [XPR_LEN-1:0]        imem_rdata_o,
  output logic                      imem_badmem_e_o,
  input  logic                      dmem_en_i,
  input  logic                      dmem_wen_i,
  input  logic [MEM_TYPE_WIDTH-1:0] dmem_size_i,
  input  logic [XPR_LEN-1:0]        dmem_addr_i,
  input  logic [XPR_LEN-1:0]        dmem_wdata_delayed_i,
  output logic                      dmem_wait_o,
  output logic [XPR_LEN-1:0]        dmem_rdata_o,
  output logic                      dmem_badmem_e_o,
  output logic                      mem_valid_o,
  output logic                      mem_write_o,
  output logic [MEM_TYPE_WIDTH-1:0] mem_size_o,
  output logic [XPR_LEN-1:0]        mem_addr_o,
  output logic [XPR_LEN-1:0]        mem_wdata_o,
  input  logic                      mem_ready_i,
  input  logic [XPR_LEN-1:0]        mem_rdata_i,
  input  logic                      mem_err_i
);

  if (MAX_DMEM_GRANTS < 1) begin : g_bad_max_grants
    $error("MAX_DMEM_GRANTS must be at least 1");
  end

  arb_owner_e dp_owner_q, dp_owner_d;
  logic       dp_write_q, dp_write_d;
  logic       sel_d_s;
  logic       force_imem_s;

`ifdef VSCALE_ARB_FAIR_EN
  vscale_arb_starve_ctr #(
    .MAX_GRANTS (MAX_DMEM_GRANTS)
  ) u_starve_ctr (
    .clk_i        (clk_i),
    .rst_i        (reset_i),
    .adv_i        (mem_ready_i),
    .dmem_grant_i (sel_d_s),
    .force_imem_o (force_imem_s)
  );
`else
  assign force_imem_s = 1'b0;
`endif

  assign sel_d_s = dmem_en_i & ~force_imem_s;

  // Address phase: dmem if granted, otherwise the always-pending word fetch
  always_comb begin
    mem_valid_o = 1'b1;
    mem_write_o = 1'b0;
    mem_size_o  = MEM_TYPE_LW;
    mem_addr_o  = imem_addr_i;
    if (sel_d_s) begin
      mem_write_o = dmem_wen_i;
      mem_size_o  = dmem_size_i;
      mem_addr_o  = dmem_addr_i;
    end else begin
      mem_write_o = 1'b0;
      mem_size_o  = MEM_TYPE_LW;
      mem_addr_o  = imem_addr_i;
    end
  end

  // Both phases move together, and only when the bus is ready
  always_comb begin
    dp_owner_d = dp_owner_q;
    dp_write_d = dp_write_q;
    if (mem_ready_i) begin
      dp_owner_d = sel_d_s ? ARB_OWNER_DMEM : ARB_OWNER_IMEM;
      dp_write_d = sel_d_s & dmem_wen_i;
    end else begin
      dp_owner_d = dp_owner_q;
      dp_write_d = dp_write_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dp_owner_q <= ARB_OWNER_NONE;
      dp_write_q <= 1'b0;
    end else begin
      dp_owner_q <= dp_owner_d;
      dp_write_q <= dp_write_d;
    end
  end

  assign imem_wait_o = ~((dp_owner_q == ARB_OWNER_IMEM) & mem_ready_i);
  assign dmem_wait_o = ((dp_owner_q == ARB_OWNER_DMEM) & ~mem_ready_i)
                     | (dmem_en_i & (~mem_ready_i | ~sel_d_s));

  assign imem_rdata_o = mem_rdata_i;
  assign dmem_rdata_o = mem_rdata_i;

  assign mem_wdata_o = ((dp_owner_q == ARB_OWNER_DMEM) & dp_write_q)
                     ? dmem_wdata_delayed_i : {XPR_LEN{1'b0}};

  assign imem_badmem_e_o = mem_err_i & mem_ready_i & (dp_owner_q == ARB_OWNER_IMEM);
  assign dmem_badmem_e_o = mem_err_i & mem_ready_i & (dp_owner_q == ARB_OWNER_DMEM);

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Directed bench for vscale_mem_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for async reset and the dmem streaming pattern.
module tb_vscale_mem_arbiter;
  import vscale_mem_arbiter_pkg::*;

  logic                      clk_i = 1'b0;
  logic                      reset_i;
  logic [XPR_LEN-1:0]        imem_addr_i;
  logic                      imem_wait_o;
  logic [XPR_LEN-1:0]        imem_rdata_o;
  logic                      imem_badmem_e_o;
  logic                      dmem_en_i;
  logic                      dmem_wen_i;
  logic [MEM_TYPE_WIDTH-1:0] dmem_size_i;
  logic [XPR_LEN-1:0]        dmem_addr_i;
  logic [XPR_LEN-1:0]        dmem_wdata_delayed_i;
  logic                      dmem_wait_o;
  logic [XPR_LEN-1:0]        dmem_rdata_o;
  logic                      dmem_badmem_e_o;
  logic                      mem_valid_o;
  logic                      mem_write_o;
  logic [MEM_TYPE_WIDTH-1:0] mem_size_o;
  logic [XPR_LEN-1:0]        mem_addr_o;
  logic [XPR_LEN-1:0]        mem_wdata_o;
  logic                      mem_ready_i;
  logic [XPR_LEN-1:0]        mem_rdata_i;
  logic                      mem_err_i;

  vscale_mem_arbiter #(.MAX_DMEM_GRANTS(4)) dut (
    .clk_i                (clk_i),
    .reset_i              (reset_i),
    .imem_addr_i          (imem_addr_i),
    .imem_wait_o          (imem_wait_o),
    .imem_rdata_o         (imem_rdata_o),
    .imem_badmem_e_o      (imem_badmem_e_o),
    .dmem_en_i            (dmem_en_i),
    .dmem_wen_i           (dmem_wen_i),
    .dmem_size_i          (dmem_size_i),
    .dmem_addr_i          (dmem_addr_i),
    .dmem_wdata_delayed_i (dmem_wdata_delayed_i),
    .dmem_wait_o          (dmem_wait_o),
    .dmem_rdata_o         (dmem_rdata_o),
    .dmem_badmem_e_o      (dmem_badmem_e_o),
    .mem_valid_o          (mem_valid_o),
    .mem_write_o          (mem_write_o),
    .mem_size_o           (mem_size_o),
    .mem_addr_o           (mem_addr_o),
    .mem_wdata_o          (mem_wdata_o),
    .mem_ready_i          (mem_ready_i),
    .mem_rdata_i          (mem_rdata_i),
    .mem_err_i            (mem_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        rdy;
    logic        den;
    logic        dwen;
    logic [2:0]  dsize;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic [31:0] iaddr;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] e_addr;
    logic        e_write;
    logic [2:0]  e_size;
    logic        e_iw;
    logic        e_dw;
    logic [31:0] e_wd;
    logic        e_ib;
    logic        e_db;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    mem_ready_i          = v.rdy;
    dmem_en_i            = v.den;
    dmem_wen_i           = v.dwen;
    dmem_size_i          = v.dsize;
    dmem_addr_i          = v.daddr;
    dmem_wdata_delayed_i = v.dwd;
    imem_addr_i          = v.iaddr;
    mem_rdata_i          = v.rdata;
    mem_err_i            = v.err;
  endtask

  logic [31:0] stream_addr [6];
  logic        stream_dw   [6];

  initial begin
    // rdy den wen size daddr dwd iaddr rdata err | addr write size iw dw wdata ib db
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 32'h0,   32'h0,        32'h0,  32'h11,       1'b0, 32'h0,   1'b0, 3'd2, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'd0, 32'h0,   32'h0,        32'h4,  32'hA0,       1'b0, 32'h4,   1'b0, 3'd2, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 3'd2, 32'h100, 32'h0,        32'h8,  32'hA1,       1'b0, 32'h100, 1'b1, 3'd2, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 3'd0, 32'h0,   32'hDEADBEEF, 32'h8,  32'h0,        1'b0, 32'h8,   1'b0, 3'd2, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 3'd0, 32'h0,   32'h0,        32'hC,  32'hA2,       1'b0, 32'hC,   1'b0, 3'd2, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'd0, 32'h200, 32'h0,        32'h10, 32'hA3,       1'b0, 32'h200, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,   32'h55,       32'h10, 32'hBAD,      1'b0, 32'h10,  1'b0, 3'd2, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,   32'h55,       32'h10, 32'hBAD,      1'b0, 32'h10,  1'b0, 3'd2, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,   32'h55,       32'h10, 32'hBAD,      1'b0, 32'h10,  1'b0, 3'd2, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'd0, 32'h0,   32'h55,       32'h10, 32'hCAFEF00D, 1'b0, 32'h10,  1'b0, 3'd2, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 3'd0, 32'h0,   32'h0,        32'h14, 32'h0,        1'b1, 32'h14,  1'b0, 3'd2, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 3'd1, 32'h300, 32'h0,        32'h18, 32'h0,        1'b1, 32'h300, 1'b0, 3'd1, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 3'd1, 32'h300, 32'h0,        32'h18, 32'h0,        1'b1, 32'h300, 1'b0, 3'd1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 3'd2, 32'h304, 32'h0,        32'h18, 32'h0,        1'b1, 32'h304, 1'b1, 3'd2, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 3'd0, 32'h0,   32'h12345678, 32'h18, 32'h77,       1'b0, 32'h18,  1'b0, 3'd2, 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0};

`ifdef VSCALE_ARB_FAIR_EN
    stream_addr = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h40, 32'h400};
    stream_dw   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    stream_addr = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h400, 32'h400};
    stream_dw   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    reset_i = 1'b1;
    drive('0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #2;
    chk("reset imem_wait", 32'(imem_wait_o), 32'd1);
    chk("reset dmem_wait", 32'(dmem_wait_o), 32'd0);
    chk("reset mem_wdata", mem_wdata_o, 32'h0);
    chk("reset badmem", {30'd0, imem_badmem_e_o, dmem_badmem_e_o}, 32'd0);

    @(negedge clk_i);
    reset_i = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      #2;
      chk($sformatf("row%0d mem_valid", i), 32'(mem_valid_o), 32'd1);
      chk($sformatf("row%0d mem_addr", i), mem_addr_o, vecs[i].e_addr);
      chk($sformatf("row%0d mem_write", i), 32'(mem_write_o), 32'(vecs[i].e_write));
      chk($sformatf("row%0d mem_size", i), 32'(mem_size_o), 32'(vecs[i].e_size));
      chk($sformatf("row%0d imem_wait", i), 32'(imem_wait_o), 32'(vecs[i].e_iw));
      chk($sformatf("row%0d dmem_wait", i), 32'(dmem_wait_o), 32'(vecs[i].e_dw));
      chk($sformatf("row%0d mem_wdata", i), mem_wdata_o, vecs[i].e_wd);
      chk($sformatf("row%0d imem_badmem", i), 32'(imem_badmem_e_o), 32'(vecs[i].e_ib));
      chk($sformatf("row%0d dmem_badmem", i), 32'(dmem_badmem_e_o), 32'(vecs[i].e_db));
      chk($sformatf("row%0d imem_rdata", i), imem_rdata_o, vecs[i].rdata);
      chk($sformatf("row%0d dmem_rdata", i), dmem_rdata_o, vecs[i].rdata);
      @(negedge clk_i);
    end

    // Async reset while a dmem data phase is outstanding
    drive('0);
    mem_ready_i = 1'b1;
    dmem_en_i   = 1'b1;
    dmem_addr_i = 32'h500;
    imem_addr_i = 32'h1C;
    @(negedge clk_i);
    dmem_en_i   = 1'b0;
    mem_ready_i = 1'b0;
    #2;
    chk("rst-seq dmem stall", 32'(dmem_wait_o), 32'd1);
    mem_ready_i = 1'b1;
    mem_err_i   = 1'b1;
    #1;
    chk("rst-seq dmem err pre", 32'(dmem_badmem_e_o), 32'd1);
    chk("rst-seq imem_wait pre", 32'(imem_wait_o), 32'd1);
    mem_ready_i = 1'b0;
    #1;
    reset_i = 1'b1;
    #1;
    chk("rst-seq async dmem_wait", 32'(dmem_wait_o), 32'd0);
    chk("rst-seq async imem_wait", 32'(imem_wait_o), 32'd1);
    mem_ready_i = 1'b1;
    #1;
    chk("rst-seq async dmem_badmem", 32'(dmem_badmem_e_o), 32'd0);
    chk("rst-seq async imem_badmem", 32'(imem_badmem_e_o), 32'd0);
    chk("rst-seq async mem_wdata", mem_wdata_o, 32'h0);
    @(negedge clk_i);
    reset_i   = 1'b0;
    mem_err_i = 1'b0;
    #2;
    chk("rst-seq first imem_wait", 32'(imem_wait_o), 32'd1);
    @(negedge clk_i);
    #2;
    chk("rst-seq second imem_wait", 32'(imem_wait_o), 32'd0);

    // Continuous dmem stream: grant pattern and dmem_wait per slot
    @(negedge clk_i);
    dmem_en_i   = 1'b1;
    dmem_wen_i  = 1'b0;
    dmem_size_i = MEM_TYPE_LW;
    dmem_addr_i = 32'h400;
    imem_addr_i = 32'h40;
    mem_ready_i = 1'b1;
    for (int s = 0; s < 6; s++) begin
      #2;
      chk($sformatf("stream%0d mem_addr", s), mem_addr_o, stream_addr[s]);
      chk($sformatf("stream%0d dmem_wait", s), 32'(dmem_wait_o), 32'(stream_dw[s]));
      @(negedge clk_i);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
